// File: rtl/div_csv_uns_seq_pkg.sv
// rtl/div_csv_uns_seq_pkg.sv - shared types and helpers for the carry-save input divider
package div_csv_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    DIVIDE  = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Legal parameter combinations: 1 or 2 quotient bits per cycle, dividend
  // width a multiple of that, divisor no wider than the dividend.
  function automatic bit cfg_ok(input int width_z, input int width_d, input int bpc);
    return ((bpc == 1) || (bpc == 2)) && ((width_z % bpc) == 0) &&
           (width_d >= 1) && (width_d <= width_z);
  endfunction

endpackage

// File: rtl/div_csv_uns_seq_if.sv
// rtl/div_csv_uns_seq_if.sv - operand/result handshake bundle for the divider
interface div_csv_uns_seq_if #(
  parameter int widthZ = 16,
  parameter int widthD = 8
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [widthZ-1:0] ZS_i;
  logic [widthZ-1:0] ZC_i;
  logic [widthD-1:0] D_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [widthZ-1:0] Q_o;
  logic [widthD-1:0] R_o;
  logic              ovf_o;
  logic              dbz_o;

  // Producer/consumer side driving operands and accepting results
  modport master (
    output in_valid_i, ZS_i, ZC_i, D_i, out_ready_i,
    input  in_ready_o, out_valid_o, Q_o, R_o, ovf_o, dbz_o
  );

  // Divider side
  modport slave (
    input  in_valid_i, ZS_i, ZC_i, D_i, out_ready_i,
    output in_ready_o, out_valid_o, Q_o, R_o, ovf_o, dbz_o
  );
endinterface

// File: rtl/div_csv_uns_seq_restore_step.sv
// rtl/div_csv_uns_seq_restore_step.sv - one combinational restoring-division step
module div_restore_step #(
  parameter int widthD = 8
) (
  input  logic [widthD:0]   p_i,
  input  logic              zbit_i,
  input  logic [widthD-1:0] d_i,
  output logic [widthD:0]   p_o,
  output logic              qbit_o
);

  logic [widthD+1:0] shifted;
  logic [widthD:0]   diff;

  // Shift in the next dividend bit and subtract D when it fits. The compare is
  // done at full width; the subtraction only needs widthD+1 bits because the
  // result is below D whenever it is kept.
  always_comb begin
    shifted = {p_i, zbit_i};
    diff    = shifted[widthD:0] - {1'b0, d_i};
    qbit_o  = (shifted >= {2'b00, d_i});
    p_o     = qbit_o ? diff : shifted[widthD:0];
  end

endmodule

// File: rtl/div_csv_uns_seq.sv
// rtl/div_csv_uns_seq.sv - sequential unsigned divider with carry-save dividend
module div_csv_uns_seq
  import div_csv_pkg::*;
#(
  parameter int widthZ       = 16,
  parameter int widthD       = 8,
  parameter int bitsPerCycle = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  div_csv_uns_seq_if.slave bus
);

  localparam int N_STEPS = widthZ / bitsPerCycle;
  localparam int CNT_W   = $clog2(N_STEPS + 1);

  generate
    if (!cfg_ok(widthZ, widthD, bitsPerCycle)) begin : g_bad_cfg
      $error("div_csv_uns_seq: bitsPerCycle must be 1 or 2, divide widthZ, and widthD <= widthZ");
    end
  endgenerate

  state_e state_q, state_d;

  logic [widthZ-1:0] zs_q, zc_q;
  logic [widthD-1:0] d_q;
  logic [widthZ-1:0] z_q;
  logic [widthD:0]   p_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [widthZ-1:0] q_q;
  logic [widthD-1:0] r_q;
  logic              ovf_q;
  logic              dbz_q;

  logic [widthZ:0]         sum_w;
  logic                    d_zero;
  logic                    last_step;
  logic [widthD:0]         p_chain [0:bitsPerCycle];
  logic [bitsPerCycle-1:0] qbits;
  logic [widthZ-1:0]       z_next;
  logic                    in_ready_w;
  logic                    out_valid_w;

  assign sum_w     = {1'b0, zs_q} + {1'b0, zc_q};
  assign d_zero    = (d_q == '0);
  assign last_step = (cnt_q == CNT_W'(N_STEPS - 1));

  // Restoring steps chained MSB first; z_q shifts the consumed dividend bits
  // out of the top while quotient bits shift in at the bottom, so after the
  // last step z_next is the complete quotient.
  assign p_chain[0] = p_q;
  generate
    for (genvar k = 0; k < bitsPerCycle; k++) begin : g_step
      div_restore_step #(.widthD(widthD)) u_step (
        .p_i    (p_chain[k]),
        .zbit_i (z_q[widthZ-1-k]),
        .d_i    (d_q),
        .p_o    (p_chain[k+1]),
        .qbit_o (qbits[bitsPerCycle-1-k])
      );
    end
  endgenerate

  assign z_next = (z_q << bitsPerCycle) | widthZ'(qbits);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid_i) state_d = RESOLVE;
      RESOLVE: state_d = d_zero ? DONE : DIVIDE;
      DIVIDE:  if (last_step) state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only
  always_comb begin
    in_ready_w  = (state_q == IDLE);
    out_valid_w = (state_q == DONE);
  end

  // Operand capture, resolution, iteration and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zs_q  <= '0;
      zc_q  <= '0;
      d_q   <= '0;
      z_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            zs_q <= bus.ZS_i;
            zc_q <= bus.ZC_i;
            d_q  <= bus.D_i;
          end
        end
        RESOLVE: begin
          ovf_q <= sum_w[widthZ];
          z_q   <= sum_w[widthZ-1:0];
          p_q   <= '0;
          cnt_q <= '0;
          dbz_q <= d_zero;
          if (d_zero) begin
            q_q <= '1;
            r_q <= sum_w[widthD-1:0];
          end
        end
        DIVIDE: begin
          z_q   <= z_next;
          p_q   <= p_chain[bitsPerCycle];
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step) begin
            q_q <= z_next;
            r_q <= p_chain[bitsPerCycle][widthD-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_w;
  assign bus.out_valid_o = out_valid_w;
  assign bus.Q_o         = q_q;
  assign bus.R_o         = r_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.dbz_o       = dbz_q;

endmodule

// File: tb/tb_div_csv_uns_seq.sv
// tb/tb_div_csv_uns_seq.sv - directed and random checks for 1 and 2 bits per cycle
module tb_div_csv_uns_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [1:0]  out_ready;
  logic [15:0] zs, zc;
  logic [7:0]  dv;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  div_csv_uns_seq_if #(.widthZ(16), .widthD(8)) if0 ();
  div_csv_uns_seq_if #(.widthZ(16), .widthD(8)) if1 ();

  assign if0.in_valid_i  = in_valid[0];
  assign if0.out_ready_i = out_ready[0];
  assign if0.ZS_i        = zs;
  assign if0.ZC_i        = zc;
  assign if0.D_i         = dv;
  assign if1.in_valid_i  = in_valid[1];
  assign if1.out_ready_i = out_ready[1];
  assign if1.ZS_i        = zs;
  assign if1.ZC_i        = zc;
  assign if1.D_i         = dv;

  div_csv_uns_seq #(.widthZ(16), .widthD(8), .bitsPerCycle(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0)
  );

  div_csv_uns_seq #(.widthZ(16), .widthD(8), .bitsPerCycle(2)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if1)
  );

  logic        in_ready_w  [2];
  logic        out_valid_w [2];
  logic [15:0] q_w [2];
  logic [7:0]  r_w [2];
  logic        ovf_w [2];
  logic        dbz_w [2];

  assign in_ready_w[0]  = if0.in_ready_o;
  assign out_valid_w[0] = if0.out_valid_o;
  assign q_w[0]         = if0.Q_o;
  assign r_w[0]         = if0.R_o;
  assign ovf_w[0]       = if0.ovf_o;
  assign dbz_w[0]       = if0.dbz_o;
  assign in_ready_w[1]  = if1.in_ready_o;
  assign out_valid_w[1] = if1.out_valid_o;
  assign q_w[1]         = if1.Q_o;
  assign r_w[1]         = if1.R_o;
  assign ovf_w[1]       = if1.ovf_o;
  assign dbz_w[1]       = if1.dbz_o;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for the accept edge, then count edges (accept
  // edge included) until out_valid is seen.
  task automatic send(input int u, input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] d, output int lat);
    int k;
    zs = a;
    zc = b;
    dv = d;
    in_valid[u] = 1'b1;
    k = 0;
    while (!in_ready_w[u] && k < 50) begin
      tick();
      k++;
    end
    tick();
    in_valid[u] = 1'b0;
    lat = 1;
    while (!out_valid_w[u] && lat < 100) begin
      tick();
      lat++;
    end
    chk($sformatf("u%0d out_valid_arrives", u), 32'(out_valid_w[u]), 32'd1);
  endtask

  task automatic check_res(input int u, input string tag, input logic [15:0] eq,
                           input logic [7:0] er, input logic eovf, input logic edbz);
    chk($sformatf("u%0d %s Q", u, tag), 32'(q_w[u]), 32'(eq));
    chk($sformatf("u%0d %s R", u, tag), 32'(r_w[u]), 32'(er));
    chk($sformatf("u%0d %s ovf", u, tag), 32'(ovf_w[u]), 32'(eovf));
    chk($sformatf("u%0d %s dbz", u, tag), 32'(dbz_w[u]), 32'(edbz));
  endtask

  task automatic handshake(input int u, input string tag);
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    chk($sformatf("u%0d %s post_hs out_valid", u, tag), 32'(out_valid_w[u]), 32'd0);
    chk($sformatf("u%0d %s post_hs in_ready", u, tag), 32'(in_ready_w[u]), 32'd1);
  endtask

  initial begin
    int          lat;
    int          exp_lat;
    logic [16:0] zsum;
    logic [15:0] mq;
    logic [7:0]  mr;
    logic [15:0] ra, rb;
    logic [7:0]  rd;

    rst       = 1'b1;
    in_valid  = 2'b00;
    out_ready = 2'b00;
    zs        = '0;
    zc        = '0;
    dv        = '0;
    repeat (3) tick();

    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d reset in_ready", u), 32'(in_ready_w[u]), 32'd1);
      chk($sformatf("u%0d reset out_valid", u), 32'(out_valid_w[u]), 32'd0);
      check_res(u, "reset", 16'h0000, 8'h00, 1'b0, 1'b0);
    end
    rst = 1'b0;
    tick();

    for (int u = 0; u < 2; u++) begin
      exp_lat = (u == 0) ? 18 : 10;

      // 0x1234 + 0x0100 = 4916 = 7*702 + 2
      send(u, 16'h1234, 16'h0100, 8'h07, lat);
      chk($sformatf("u%0d basic latency", u), 32'(lat), 32'(exp_lat));
      check_res(u, "basic", 16'h02BE, 8'h02, 1'b0, 1'b0);
      handshake(u, "basic");

      // Sum wraps to exactly 0x10000
      send(u, 16'hFFFF, 16'h0001, 8'h03, lat);
      check_res(u, "wrap", 16'h0000, 8'h00, 1'b1, 1'b0);
      handshake(u, "wrap");

      // Divide by zero, then hold the result under back-pressure
      send(u, 16'h00FF, 16'h0000, 8'h00, lat);
      chk($sformatf("u%0d dbz within 3", u), 32'(lat <= 3), 32'd1);
      check_res(u, "dbz", 16'hFFFF, 8'hFF, 1'b0, 1'b1);
      zs = 16'h0011;
      zc = 16'h0022;
      dv = 8'h05;
      in_valid[u] = 1'b1;
      for (int c = 0; c < 5; c++) begin
        tick();
        check_res(u, $sformatf("stall%0d", c), 16'hFFFF, 8'hFF, 1'b0, 1'b1);
        chk($sformatf("u%0d stall%0d in_ready", u, c), 32'(in_ready_w[u]), 32'd0);
        chk($sformatf("u%0d stall%0d out_valid", u, c), 32'(out_valid_w[u]), 32'd1);
      end
      in_valid[u] = 1'b0;
      handshake(u, "dbz");
      repeat (3) tick();
      chk($sformatf("u%0d no phantom accept", u), 32'(out_valid_w[u]), 32'd0);

      // 0xFFFF / 0xFF = 257 exactly
      send(u, 16'hFFFF, 16'h0000, 8'hFF, lat);
      check_res(u, "maxdiv", 16'h0101, 8'h00, 1'b0, 1'b0);
      handshake(u, "maxdiv");

      // 0x8000 + 0x8001 = 0x10001 -> dividend 1
      send(u, 16'h8000, 16'h8001, 8'h01, lat);
      check_res(u, "d1ovf", 16'h0001, 8'h00, 1'b1, 1'b0);
      handshake(u, "d1ovf");

      // Dividend smaller than divisor
      send(u, 16'h0005, 16'h0000, 8'hFA, lat);
      check_res(u, "small", 16'h0000, 8'h05, 1'b0, 1'b0);
      handshake(u, "small");

      // 0xABCD + 0x1111 = 0xBCDE = 128*0x179 + 0x5E
      send(u, 16'hABCD, 16'h1111, 8'h80, lat);
      check_res(u, "pow2", 16'h0179, 8'h5E, 1'b0, 1'b0);
      handshake(u, "pow2");

      // Reset six cycles after accept, while still dividing
      zs = 16'h4321;
      zc = 16'h0000;
      dv = 8'h09;
      in_valid[u] = 1'b1;
      tick();
      in_valid[u] = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk($sformatf("u%0d midrst in_ready", u), 32'(in_ready_w[u]), 32'd1);
      chk($sformatf("u%0d midrst out_valid", u), 32'(out_valid_w[u]), 32'd0);
      chk($sformatf("u%0d midrst Q", u), 32'(q_w[u]), 32'd0);
      chk($sformatf("u%0d midrst R", u), 32'(r_w[u]), 32'd0);
      send(u, 16'h1234, 16'h0100, 8'h07, lat);
      chk($sformatf("u%0d after_rst latency", u), 32'(lat), 32'(exp_lat));
      check_res(u, "after_rst", 16'h02BE, 8'h02, 1'b0, 1'b0);
      handshake(u, "after_rst");
    end

    // Random operands with random idle gaps and result stalls
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 800; n++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rd = (($urandom_range(0, 31)) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        zsum = {1'b0, ra} + {1'b0, rb};
        if (rd == 8'h00) begin
          mq = 16'hFFFF;
          mr = zsum[7:0];
        end else begin
          mq = zsum[15:0] / {8'h00, rd};
          mr = 8'(zsum[15:0] % {8'h00, rd});
        end
        repeat ($urandom_range(0, 2)) tick();
        send(u, ra, rb, rd, lat);
        repeat ($urandom_range(0, 2)) tick();
        check_res(u, $sformatf("rnd%0d", n), mq, mr, zsum[16], (rd == 8'h00));
        if (rd != 8'h00) begin
          chk($sformatf("u%0d rnd%0d R<D", u, n), 32'(r_w[u] < rd), 32'd1);
        end
        handshake(u, $sformatf("rnd%0d", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
